// File: rtl/contador_updown_param.sv
// Parameterised up/down counter with clamped parallel load, terminal count and boundary pulse.
// Define CONTADOR_SATURATE_EN to hold at the boundaries instead of wrapping modulo MAX_VAL+1.
module contador_updown_param #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_atMax;
  logic             w_atZero;
  logic             w_boundary;
  logic [WIDTH-1:0] w_loadVal;
  logic [WIDTH-1:0] w_next;

  assign w_atMax    = (r_q == MAX_VAL);
  assign w_atZero   = (r_q == ZERO);
  assign w_boundary = up ? w_atMax : w_atZero;
  assign w_loadVal  = (d > MAX_VAL) ? MAX_VAL : d;

  // The boundary value is chosen explicitly so q never holds anything above MAX_VAL.
  always_comb begin
    w_next = r_q;
    if (up) begin
      if (w_atMax) begin
`ifdef CONTADOR_SATURATE_EN
        w_next = r_q;
`else
        w_next = ZERO;
`endif
      end else begin
        w_next = r_q + ONE;
      end
    end else begin
      if (w_atZero) begin
`ifdef CONTADOR_SATURATE_EN
        w_next = r_q;
`else
        w_next = MAX_VAL;
`endif
      end else begin
        w_next = r_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= ZERO;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= w_loadVal;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= w_next;
      r_wrap <= w_boundary;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign tc   = en & w_boundary;

endmodule

// File: tb/tb_contador_updown_param.sv
// Bench for contador_updown_param: two instances (MAX_VAL 15 and 9) driven in lockstep and
// compared against an arithmetic reference model; honours CONTADOR_SATURATE_EN.
module tb_contador_updown_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] q15;
  logic [3:0] q9;
  logic       tc15;
  logic       tc9;
  logic       wrap15;
  logic       wrap9;

  int errorCount;
  int checkCount;

  int  mq15;
  int  mq9;
  int  mw15;
  int  mw9;
  bit  modelKnown;

`ifdef CONTADOR_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  contador_updown_param #(.WIDTH(4), .MAX_VAL(4'd15)) dut15 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q15), .tc(tc15), .wrap(wrap15)
  );

  contador_updown_param #(.WIDTH(4), .MAX_VAL(4'd9)) dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q9), .tc(tc9), .wrap(wrap9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference behaviour in plain modular arithmetic over the range 0..maxVal.
  task automatic modelStep(input int curQ, input int maxVal, input bit iRst, input bit iLoad,
                           input bit iEn, input bit iUp, input int iD,
                           output int nextQ, output int nextWrap);
    nextQ    = curQ;
    nextWrap = 0;
    if (iRst) begin
      nextQ = 0;
    end else if (iLoad) begin
      nextQ = (iD > maxVal) ? maxVal : iD;
    end else if (iEn) begin
      if (iUp) begin
        nextWrap = (curQ + 1 > maxVal) ? 1 : 0;
        nextQ    = (curQ + 1) % (maxVal + 1);
      end else begin
        nextWrap = (curQ - 1 < 0) ? 1 : 0;
        nextQ    = (curQ - 1 + maxVal + 1) % (maxVal + 1);
      end
      if (nextWrap == 1 && SATURATE) nextQ = curQ;
    end
  endtask

  function automatic int modelTc(input int curQ, input int maxVal, input bit iEn, input bit iUp);
    return (iEn && ((iUp && curQ == maxVal) || (!iUp && curQ == 0))) ? 1 : 0;
  endfunction

  // One clock of stimulus: check tc before the edge, then q/wrap after it.
  task automatic applyStimulus(input bit iRst, input bit iLoad, input bit iEn, input bit iUp,
                               input int iD, input string tag);
    int n15, n9, w15, w9;
    rst  = iRst;
    load = iLoad;
    en   = iEn;
    up   = iUp;
    d    = 4'(iD);
    #1;
    if (modelKnown) begin
      checkOutput({tag, ".tc15"}, 32'(tc15), 32'(modelTc(mq15, 15, iEn, iUp)));
      checkOutput({tag, ".tc9"},  32'(tc9),  32'(modelTc(mq9, 9, iEn, iUp)));
    end
    modelStep(mq15, 15, iRst, iLoad, iEn, iUp, iD, n15, w15);
    modelStep(mq9,  9,  iRst, iLoad, iEn, iUp, iD, n9,  w9);
    @(posedge clk);
    mq15 = n15; mw15 = w15;
    mq9  = n9;  mw9  = w9;
    if (iRst) modelKnown = 1'b1;
    @(negedge clk);
    if (modelKnown) begin
      checkOutput({tag, ".q15"},    32'(q15),    32'(mq15));
      checkOutput({tag, ".wrap15"}, 32'(wrap15), 32'(mw15));
      checkOutput({tag, ".q9"},     32'(q9),     32'(mq9));
      checkOutput({tag, ".wrap9"},  32'(wrap9),  32'(mw9));
      checkOutput({tag, ".range9"}, 32'(q9 <= 4'd9), 32'd1);
    end
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    modelKnown = 1'b0;
    mq15 = 0; mq9 = 0; mw15 = 0; mw9 = 0;
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
    @(negedge clk);

    // Reset with every other control active, then full upward sweep through the wrap.
    applyStimulus(1, 1, 1, 1, 5, "reset");
    checkOutput("reset.q15", 32'(q15), 32'd0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 1, 0, "countUp");

    // Downward from zero on both instances.
    applyStimulus(1, 0, 0, 0, 0, "rstDown");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, 0, "countDown");

    // Clamped load, then load beating enable.
    applyStimulus(0, 1, 0, 0, 12, "loadClamp");
    checkOutput("loadClamp.q9", 32'(q9), 32'd9);
    applyStimulus(0, 1, 1, 1, 3, "loadWins");
    checkOutput("loadWins.q9", 32'(q9), 32'd3);

    // Reset mid-count then resume.
    applyStimulus(0, 1, 0, 1, 6, "load6");
    applyStimulus(0, 0, 1, 1, 0, "to7");
    applyStimulus(1, 0, 1, 1, 0, "midRst");
    applyStimulus(0, 0, 1, 1, 0, "resume");
    checkOutput("resume.q15", 32'(q15), 32'd1);

    // Blocked/wrapping steps at the top, then reversing direction.
    applyStimulus(0, 1, 0, 1, 15, "load15");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, "topUp");
    applyStimulus(0, 0, 1, 0, 0, "reverse");
    applyStimulus(0, 0, 1, 1, 0, "reverseBack");

    // Enable low with direction toggling: nothing moves.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, i[0], 0, "idle");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 15)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/contador_updown_param.md
CONTADOR_UPDOWN_PARAM -- requirements
Module: contador_updown_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: highest count value; legal range 1..2**WIDTH-1.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port en  input  1  count enable; the counter steps only when this is 1.
REQ-006 Port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  synchronous parallel-load strobe.
REQ-008 Port d  input  WIDTH  parallel-load value.
REQ-009 Port q  output  WIDTH  registered count value.
REQ-010 Port tc  output  1  terminal count; combinational.
REQ-011 Port wrap  output  1  registered one-cycle pulse that marks a boundary event.

Function
REQ-012 Update priority per rising edge SHALL be rst > load > en; with none active, q holds.
REQ-013 Load: q <= d when d <= MAX_VAL; otherwise q <= MAX_VAL (clamp); wrap <= 0.
REQ-014 Count up (en=1, up=1): q <= q+1 when q < MAX_VAL; at q == MAX_VAL, q <= 0 and wrap <= 1.
REQ-015 Count down (en=1, up=0): q <= q-1 when q > 0; at q == 0, q <= MAX_VAL and wrap <= 1.
REQ-016 tc = en & ((up & q==MAX_VAL) | (~up & q==0)); tc is independent of load.
REQ-017 wrap SHALL be 1 for exactly the single cycle after a boundary step and 0 in every other cycle.
REQ-018 Step latency: the new q value is visible one cycle after the enabling edge; there is no pipeline.
REQ-019 A change of up while en=1 SHALL take effect on the same edge, with no dead cycle.
REQ-020 When load and en are both asserted, load wins; no step and no wrap occur in that cycle.
REQ-021 All arithmetic SHALL be WIDTH bits wide, with no out-of-range intermediate value ever stored in q.
REQ-022 When MAX_VAL < 2**WIDTH-1, the values above MAX_VAL SHALL be unreachable, except through clamped load, which maps them to MAX_VAL.

Reset
REQ-023 rst=1 at a rising edge: q <= 0 and wrap <= 0, regardless of en, load or up.
REQ-024 rst asserted mid-count discards the pending step; counting resumes from 0 on the first edge with rst=0.
REQ-025 There SHALL be no asynchronous path from rst to any output.

Configuration
REQ-026 Macro CONTADOR_SATURATE_EN selects saturating mode.
REQ-027 With CONTADOR_SATURATE_EN defined:
- at q == MAX_VAL with up=1, q holds; at q == 0 with up=0, q holds.
- wrap is pulsed for one cycle on every such blocked step, which serves as the saturation indication.
- tc behaviour is unchanged.
REQ-028 Without CONTADOR_SATURATE_EN, the modulo wrap of REQ-014 and REQ-015 applies.
REQ-029 The macro SHALL NOT alter the ports, the reset value or the load behaviour.

Verification
REQ-030 WIDTH=4, MAX_VAL=15: rst for 1 cycle, then en=1, up=1 for 17 cycles -> q = 0,1,..,15,0,1; tc=1 in the q=15 cycle; wrap=1 in the cycle when q returns to 0.
REQ-031 WIDTH=4, MAX_VAL=9, up=0 from q=0 -> q = 9,8,..; wrap pulses once; q never exceeds 9.
REQ-032 load=1 with d=12 and MAX_VAL=9 -> q=9 next cycle; load=1 and en=1 with d=3 -> q=3, wrap=0.
REQ-033 At q=7 counting up, assert rst for one cycle -> q=0 next edge; then en=1 -> q=1.
REQ-034 CONTADOR_SATURATE_EN defined, WIDTH=4, MAX_VAL=15: at q=15 with up=1 for 3 cycles -> q stays 15 and wrap=1 each cycle; up=0 -> q=14.
REQ-035 en=0 with up toggling for 5 cycles -> q unchanged, tc=0, wrap=0.
